// File: rtl/timer_dev.sv
// timer_dev: 32-bit down-counting timer with a small register file
// (CTRL / PRESET / COUNT) and a maskable interrupt request.
// The counter walks IDLE -> LOAD -> CNT -> INT; INT either stops the timer
// (one-shot) or reloads it (auto-reload).
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  ctrl_r;
  logic [3:0]  ctrl_fsm_s;
  logic [3:0]  ctrl_nxt_s;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic [31:0] count_nxt_s;
  logic        irq_flag_r;
  logic        irq_flag_fsm_s;
  logic        irq_flag_nxt_s;
  logic        irq_r;
  logic        ctrl_we_s;
  logic        preset_we_s;
  logic        enable_s;
  logic        reload_mode_s;
  logic        count_zero_s;

  assign ctrl_we_s     = We && (Addr == ADDR_CTRL);
  assign preset_we_s   = We && (Addr == ADDR_PRESET);
  assign enable_s      = ctrl_r[0];
  // Only mode 1 reloads; modes 2 and 3 fall back to one-shot behaviour.
  assign reload_mode_s = (ctrl_r[2:1] == 2'b01);
  assign count_zero_s  = (count_r == 32'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision for the counting sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_s) state_nxt_s = LOAD;
        else          state_nxt_s = IDLE;
      end
      LOAD: state_nxt_s = CNT;
      CNT: begin
        if (!enable_s)         state_nxt_s = IDLE;
        else if (count_zero_s) state_nxt_s = INT;
        else                   state_nxt_s = CNT;
      end
      INT: begin
        if (reload_mode_s) state_nxt_s = LOAD;
        else               state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-driven updates of COUNT, CTRL[0] and irq_flag.
  always_comb begin
    count_nxt_s    = count_r;
    ctrl_fsm_s     = ctrl_r;
    irq_flag_fsm_s = irq_flag_r;
    case (state_r)
      IDLE: count_nxt_s = count_r;
      LOAD: count_nxt_s = preset_r;
      CNT: begin
        if (enable_s && count_zero_s) begin
          irq_flag_fsm_s = 1'b1;
        end else if (enable_s) begin
          // Decrement only when non-zero, so COUNT can never wrap.
          count_nxt_s = count_r - 32'd1;
        end else begin
          count_nxt_s = count_r;
        end
      end
      INT: begin
        if (reload_mode_s) begin
          irq_flag_fsm_s = 1'b0;
        end else begin
          ctrl_fsm_s[0] = 1'b0;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // A CTRL write overrides the state-driven Enable clear and clears irq_flag.
  assign ctrl_nxt_s     = ctrl_we_s ? DIn[3:0] : ctrl_fsm_s;
  assign irq_flag_nxt_s = ctrl_we_s ? 1'b0     : irq_flag_fsm_s;

  // Register file, counter, flag and the registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r     <= 4'd0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      count_r    <= count_nxt_s;
      irq_flag_r <= irq_flag_nxt_s;
      // IRQ tracks irq_flag & CTRL[3] from flops only, no path from DIn/We.
      irq_r      <= irq_flag_nxt_s & ctrl_nxt_s[3];
      if (preset_we_s) preset_r <= DIn;
      else             preset_r <= preset_r;
    end
  end

  // Combinational read mux.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      ADDR_CTRL:   DOut = {28'd0, ctrl_r};
      ADDR_PRESET: DOut = preset_r;
      ADDR_COUNT:  DOut = count_r;
      default:     DOut = 32'd0;
    endcase
  end

  assign IRQ = irq_r;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed scenarios with literal expectations plus a long
// randomized run, all checked against a behavioural model of the timer.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  Addr = 2'd0;
  logic        We = 1'b0;
  logic [31:0] DIn = 32'd0;
  logic [31:0] DOut;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    int          phase;
  } mstate_t;

  mstate_t m;

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (Addr),
    .We   (We),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial forever #10 clk = ~clk;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.ctrl = 4'd0; s.preset = 32'd0; s.count = 32'd0; s.flag = 1'b0; s.phase = PH_IDLE;
    return s;
  endfunction

  // One clock of the timer, written directly from its behavioural rules.
  function automatic mstate_t model_next(mstate_t s, logic [1:0] a, logic w, logic [31:0] d);
    mstate_t n = s;
    bit reload = (s.ctrl[2:1] == 2'd1);
    case (s.phase)
      PH_IDLE: if (s.ctrl[0]) n.phase = PH_LOAD;
      PH_LOAD: begin n.count = s.preset; n.phase = PH_CNT; end
      PH_CNT: begin
        if (!s.ctrl[0])          n.phase = PH_IDLE;
        else if (s.count == 0)   begin n.phase = PH_INT; n.flag = 1'b1; end
        else                     n.count = s.count - 1;
      end
      PH_INT: begin
        if (reload) begin n.phase = PH_LOAD; n.flag = 1'b0; end
        else        begin n.ctrl[0] = 1'b0; n.phase = PH_IDLE; end
      end
      default: n.phase = PH_IDLE;
    endcase
    if (w && a == 2'd0) begin n.ctrl = d[3:0]; n.flag = 1'b0; end
    if (w && a == 2'd1) n.preset = d;
    return n;
  endfunction

  function automatic logic [31:0] exp_dout(mstate_t s, logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, Addr, We, DIn);
  end

  // Per-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_dout", DOut, exp_dout(m, Addr));
      check("cyc_irq", {31'd0, IRQ}, {31'd0, m.flag & m.ctrl[3]});
    end
  end

  task automatic cyc(input logic [1:0] a, input logic w, input logic [31:0] d);
    Addr = a; We = w; DIn = d;
    @(posedge clk); @(negedge clk); #1;
    We = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(2'd2, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; Addr = 2'd0; We = 1'b0; DIn = 32'd0;
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] v);
    Addr = a; #1;
    check({nm, "_dut"}, DOut, v);
    check({nm, "_model"}, exp_dout(m, a), v);
  endtask

  task automatic expect_irq(input string nm, input logic v);
    check({nm, "_dut"}, {31'd0, IRQ}, {31'd0, v});
    check({nm, "_model"}, {31'd0, m.flag & m.ctrl[3]}, {31'd0, v});
  endtask

  initial begin
    logic [31:0] os_count [1:6];
    logic        os_irq   [1:6];
    os_count = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    os_irq   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state.
    do_reset();
    expect_reg("rst_ctrl", 2'd0, 32'd0);
    expect_reg("rst_preset", 2'd1, 32'd0);
    expect_reg("rst_count", 2'd2, 32'd0);
    expect_irq("rst_irq", 1'b0);

    // One-shot, PRESET=3, CTRL=0x9.
    cyc(2'd1, 1'b1, 32'd3);
    cyc(2'd0, 1'b1, 32'h9);
    expect_reg("os_ctrl0", 2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      expect_reg($sformatf("os_count_e%0d", k), 2'd2, os_count[k]);
      expect_irq($sformatf("os_irq_e%0d", k), os_irq[k]);
    end
    idle(1);
    expect_reg("os_ctrl_e7", 2'd0, 32'h8);
    expect_irq("os_irq_e7", 1'b1);
    idle(3);
    expect_irq("os_irq_hold", 1'b1);
    cyc(2'd0, 1'b1, 32'h8);
    expect_irq("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=2, CTRL=0xB: one-cycle pulse every 5 cycles.
    do_reset();
    cyc(2'd1, 1'b1, 32'd2);
    cyc(2'd0, 1'b1, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      expect_irq($sformatf("ar_irq_e%0d", k), (k % 5) == 0);
    end
    expect_reg("ar_ctrl", 2'd0, 32'hB);

    // Masked, PRESET=1, CTRL=0x1; then CTRL=0x9 restarts.
    do_reset();
    cyc(2'd1, 1'b1, 32'd1);
    cyc(2'd0, 1'b1, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      expect_irq($sformatf("mk_irq_e%0d", k), 1'b0);
    end
    expect_reg("mk_ctrl", 2'd0, 32'h0);
    cyc(2'd0, 1'b1, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      expect_irq($sformatf("mk_restart_e%0d", k), k == 4);
    end

    // PRESET=0 reaches INT one cycle after LOAD.
    do_reset();
    cyc(2'd0, 1'b1, 32'h9);
    idle(2);
    expect_irq("p0_irq_e2", 1'b0);
    idle(1);
    expect_irq("p0_irq_e3", 1'b1);
    expect_reg("p0_count", 2'd2, 32'd0);

    // Pause at 7, ignored writes, reload from 10, PRESET write during CNT.
    do_reset();
    cyc(2'd1, 1'b1, 32'd10);
    cyc(2'd0, 1'b1, 32'h1);
    idle(4);
    expect_reg("pz_count8", 2'd2, 32'd8);
    cyc(2'd0, 1'b1, 32'h0);
    expect_reg("pz_count7", 2'd2, 32'd7);
    idle(3);
    expect_reg("pz_hold", 2'd2, 32'd7);
    cyc(2'd2, 1'b1, 32'h1234);
    expect_reg("pz_addr2_wr", 2'd2, 32'd7);
    cyc(2'd3, 1'b1, 32'hFFFF_FFFF);
    expect_reg("pz_addr3_rd", 2'd3, 32'd0);
    cyc(2'd0, 1'b1, 32'h1);
    idle(1);
    expect_reg("pz_load_e1", 2'd2, 32'd7);
    idle(1);
    expect_reg("pz_reload_e2", 2'd2, 32'd10);
    cyc(2'd1, 1'b1, 32'd4);
    expect_reg("pz_presetwr_count", 2'd2, 32'd9);
    expect_reg("pz_presetwr_preset", 2'd1, 32'd4);

    // Collision: CTRL=0x9 written on the INT edge in one-shot mode.
    do_reset();
    cyc(2'd1, 1'b1, 32'd1);
    cyc(2'd0, 1'b1, 32'h9);
    idle(4);
    expect_irq("col_irq_int", 1'b1);
    cyc(2'd0, 1'b1, 32'h9);
    expect_reg("col_ctrl", 2'd0, 32'h9);
    expect_irq("col_irq_cleared", 1'b0);
    idle(4);
    expect_irq("col_irq_again", 1'b1);

    // Async reset mid-count at COUNT=5.
    do_reset();
    cyc(2'd1, 1'b1, 32'd10);
    cyc(2'd0, 1'b1, 32'h9);
    idle(7);
    expect_reg("ar_count5", 2'd2, 32'd5);
    rst = 1'b1;
    expect_reg("ar_count_in_rst", 2'd2, 32'd0);
    expect_irq("ar_irq_in_rst", 1'b0);
    rst = 1'b0;
    idle(5);
    expect_reg("ar_count_after", 2'd2, 32'd0);
    expect_reg("ar_ctrl_after", 2'd0, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [1:0]  a;
      logic        w;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 9) < 3);
      case (a)
        2'd0: begin
          d = $urandom;
          d[0] = ($urandom_range(0, 3) != 0);
        end
        2'd1:    d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      cyc(a, w, d);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
